// File: rtl/la_ioring_seq.sv
// IO ring supply-control sequencer: walks the ioring control bus toward a programmed
// target one bit per step, with a programmable settle delay between bit changes.
module la_ioring_seq #(
    parameter int                RINGW = 8,
    parameter int                CNTW  = 8,
    parameter logic [RINGW-1:0]  INIT  = '1,
    parameter logic [CNTW-1:0]   DELAY = CNTW'(3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [RINGW-1:0] cfg_target,
    input  logic [CNTW-1:0]  cfg_delay,
    output logic [RINGW-1:0] ioring,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state_r;
    logic [RINGW-1:0] target_r;
    logic [CNTW-1:0]  delay_r;
    logic [CNTW-1:0]  cnt_r;

    logic [RINGW-1:0] clr_s;
    logic [RINGW-1:0] set_s;
    logic [RINGW-1:0] step_ring_s;
    logic             mismatch_s;
    logic             step_left_s;

    // One-hot of the highest set bit of v (zero when v is zero).
    function automatic logic [RINGW-1:0] hi_bit(input logic [RINGW-1:0] v);
        logic [RINGW-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = RINGW - 1; i >= 0; i--) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // One-hot of the lowest set bit of v (zero when v is zero).
    function automatic logic [RINGW-1:0] lo_bit(input logic [RINGW-1:0] v);
        logic [RINGW-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < RINGW; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Next ring value for a single step: power-down beats power-up, so bits that must
    // clear go first (highest index first), then bits that must set (lowest first).
    always_comb begin
        clr_s      = ioring & ~target_r;
        set_s      = ~ioring & target_r;
        mismatch_s = |(clr_s | set_s);
        if (|clr_s) begin
            step_ring_s = ioring & ~hi_bit(clr_s);
        end else begin
            step_ring_s = ioring | lo_bit(set_s);
        end
        step_left_s = (step_ring_s != target_r);
    end

    // Sequencer FSM with its datapath registers and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            target_r <= INIT;
            delay_r  <= DELAY;
            cnt_r    <= '0;
            ioring   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cfg_valid) begin
                        target_r <= cfg_target;
                        delay_r  <= cfg_delay;
                    end else if (mismatch_s) begin
                        state_r <= STEP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STEP: begin
                    ioring <= step_ring_s;
                    cnt_r  <= delay_r;
                    if (delay_r != '0) begin
                        state_r <= WAIT;
                    end else if (step_left_s) begin
                        state_r <= STEP;
                    end else begin
                        state_r <= IDLE;
                        done    <= 1'b1;
                    end
                end
                WAIT: begin
                    // cnt holds at 1 on the exit edge rather than wrapping through 0.
                    if (cnt_r == CNTW'(1)) begin
                        if (mismatch_s) begin
                            state_r <= STEP;
                        end else begin
                            state_r <= IDLE;
                            done    <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNTW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_r != IDLE);
    assign cfg_ready = (state_r == IDLE);

endmodule

// File: tb/tb_la_ioring_seq.sv
// Directed bench for la_ioring_seq: expected bit changes and done pulses are derived from
// the sequencing rules, queued when stimulus is applied, and popped as the ring moves.
module tb_la_ioring_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_target;
    logic [7:0] cfg_delay;
    logic [7:0] ioring;
    logic       busy;
    logic       done;

    la_ioring_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_target (cfg_target),
        .cfg_delay  (cfg_delay),
        .ioring     (ioring),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] val;
    } chg_t;

    chg_t chg_q[$];
    int   done_q[$];
    logic exp_busy [0:299];
    int   ntests = 0;
    int   nfail  = 0;

    int         pend_edge = 0;
    logic [7:0] pend_t    = 8'h00;
    logic [7:0] pend_d    = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        chg_q.delete();
        done_q.delete();
        for (int i = 0; i < 300; i++) exp_busy[i] = 1'b0;
    endtask

    // Queue the changes a sequence must produce, given the edge s of its IDLE->STEP move.
    task automatic push_seq(input logic [7:0] start, input logic [7:0] tgt,
                            input int dly, input int s);
        logic [7:0] ring;
        int         n;
        int         de;
        chg_t       c;
        ring = start;
        n    = 0;
        for (int b = 7; b >= 0; b--) begin
            if (ring[b] && !tgt[b]) begin
                ring[b] = 1'b0;
                c.at    = s + 1 + n * (dly + 1);
                c.val   = ring;
                chg_q.push_back(c);
                n++;
            end
        end
        for (int b = 0; b < 8; b++) begin
            if (!ring[b] && tgt[b]) begin
                ring[b] = 1'b1;
                c.at    = s + 1 + n * (dly + 1);
                c.val   = ring;
                chg_q.push_back(c);
                n++;
            end
        end
        if (n > 0) begin
            de = s + n * (dly + 1);
            done_q.push_back(de);
            for (int e = s; e < de; e++) exp_busy[e] = 1'b1;
        end
    endtask

    // Run ncyc edges (numbered from 1), completing handshakes and scoring every output.
    task automatic watch(input int ncyc, input int exp_xfer);
        logic [7:0] prev;
        int         xfer;
        int         bad_busy;
        int         bad_ready;
        logic       will_xfer;
        chg_t       c;
        int         d;
        prev      = ioring;
        xfer      = 0;
        bad_busy  = 0;
        bad_ready = 0;
        for (int e = 1; e <= ncyc; e++) begin
            will_xfer = cfg_valid && cfg_ready;
            @(posedge clk);
            #1;
            if (will_xfer) begin
                cfg_valid = 1'b0;
                xfer      = e;
            end
            if (pend_edge == e) begin
                cfg_valid  = 1'b1;
                cfg_target = pend_t;
                cfg_delay  = pend_d;
            end
            if (ioring !== prev) begin
                if (chg_q.size() == 0) begin
                    chk("chg_unexpected", 32'(ioring), 32'(prev));
                end else begin
                    c = chg_q.pop_front();
                    chk("chg_val", 32'(ioring), 32'(c.val));
                    chk("chg_edge", e, c.at);
                end
            end
            prev = ioring;
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'h0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_edge", e, d);
                end
            end
            if (busy !== exp_busy[e]) bad_busy++;
            if (cfg_ready !== !exp_busy[e]) bad_ready++;
        end
        chk("chg_left", chg_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        chk("busy_bad_cycles", bad_busy, 0);
        chk("ready_bad_cycles", bad_ready, 0);
        chk("xfer_edge", xfer, exp_xfer);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_target = 8'h00;
        cfg_delay  = 8'h00;

        // Reset state, then power-on bring-up to INIT with DELAY=3.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ioring", 32'(ioring), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);
        clear_exp();
        push_seq(8'h00, 8'hFF, 3, 1);
        rst = 1'b0;
        watch(40, 0);

        // Power-down of the upper nibble with zero delay.
        clear_exp();
        cfg_target = 8'h0F;
        cfg_delay  = 8'd0;
        cfg_valid  = 1'b1;
        push_seq(8'hFF, 8'h0F, 0, 2);
        watch(10, 1);

        // Mixed direction: clears first, then sets, delay 1.
        clear_exp();
        cfg_target = 8'hF0;
        cfg_delay  = 8'd1;
        cfg_valid  = 1'b1;
        push_seq(8'h0F, 8'hF0, 1, 2);
        watch(24, 1);

        // New cfg held while busy transfers only on the first IDLE edge.
        clear_exp();
        cfg_target = 8'h00;
        cfg_delay  = 8'd0;
        cfg_valid  = 1'b1;
        pend_edge  = 3;
        pend_t     = 8'hAA;
        pend_d     = 8'd2;
        push_seq(8'hF0, 8'h00, 0, 2);
        push_seq(8'h00, 8'hAA, 2, 8);
        watch(24, 7);
        pend_edge = 0;

        // Target equal to current ring: accepted, nothing moves.
        clear_exp();
        cfg_target = 8'hAA;
        cfg_delay  = 8'd5;
        cfg_valid  = 1'b1;
        watch(10, 1);

        // Reset in WAIT midway through a sequence, then a fresh bring-up from bit 0.
        cfg_target = 8'h55;
        cfg_delay  = 8'd2;
        cfg_valid  = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_ioring", 32'(ioring), 32'h0A);
        chk("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ioring", 32'(ioring), 32'h00);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_ready", 32'(cfg_ready), 32'h1);
        clear_exp();
        push_seq(8'h00, 8'hFF, 3, 1);
        rst = 1'b0;
        watch(40, 0);

        // Maximum settle delay.
        clear_exp();
        cfg_target = 8'hFE;
        cfg_delay  = 8'd255;
        cfg_valid  = 1'b1;
        push_seq(8'hFF, 8'hFE, 255, 2);
        watch(262, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/la_ioring_seq.md
# la_ioring_seq

IO ring supply-control sequencer. It drives the RINGW-bit ioring control bus that runs through the pad ring and its cut cells on one side of the die. It walks the ring from its current value toward a programmed target one bit at a time, with a programmable settle delay between bit changes, to limit inrush and ground bounce. Bits power up lowest-index first and power down highest-index first.

## Interface
Parameters:
- RINGW, 8, width of the ioring control bus
- CNTW, 8, width of the settle-delay counter
- INIT, all ones (RINGW bits), target ring value loaded at reset
- DELAY, 3, settle delay (cycles) loaded at reset

Ports:
- clk  input  1  single clock; all logic on its rising edge
- rst  input  1  reset, synchronous, active-high
- cfg_valid  input  1  new target/delay offered
- cfg_ready  output  1  block accepts cfg this cycle (high only in IDLE)
- cfg_target  input  RINGW  requested ring value
- cfg_delay  input  CNTW  settle delay applied after each bit change
- ioring  output  RINGW  ring control bus to pad ring and cut cells (registered)
- busy  output  1  high while state is not IDLE
- done  output  1  one-cycle pulse when ioring reaches target

## Operation
- Registers: target[RINGW], delay[CNTW], cnt[CNTW], ioring[RINGW], state.
- Reset values: ioring=0, target=INIT, delay=DELAY, cnt=0, state=IDLE, done=0. Derived outputs follow: busy=0, cfg_ready=1.
- States: IDLE, STEP, WAIT.
- IDLE:
  - If cfg_valid: load target=cfg_target and delay=cfg_delay, then stay in IDLE. cfg has priority over a pending mismatch.
  - Else if ioring!=target: go to STEP.
  - Else: stay in IDLE.
- STEP (exactly one bit changes, and only in this state):
  - If any bit has ioring=1 and target=0: clear the highest-index such bit.
  - Else: set the lowest-index bit with ioring=0 and target=1.
  - Then load cnt=delay.
  - If delay!=0: go to WAIT.
  - If delay==0 and a mismatch remains after the update: go to STEP.
  - If delay==0 and no mismatch remains: go to IDLE and pulse done.
- WAIT:
  - Decrement cnt each cycle.
  - When cnt is 1 on an edge, leave WAIT: go to STEP if a mismatch remains, else go to IDLE and pulse done.
  - WAIT therefore lasts exactly delay cycles.
- cfg is not accepted while busy. cfg_valid is held by the sender, and target is never modified mid-sequence.
- done is registered: high for exactly the one cycle after the edge that enters IDLE with ioring==target.
- An IDLE→STEP entry with no resulting change cannot occur, because STEP is entered only on a mismatch.
- rst asserted in any state restores all reset values on the next edge, including dropping ioring to 0 at once with no sequencing. Partial progress is lost.

## Timing
- Edge numbering: edge 1 is the first rising edge with rst low.
- First bit change is visible after the second edge following a mismatch in IDLE (IDLE→STEP, then STEP updates ioring).
- Bit-change spacing: delay+1 cycles.
- Full sequence of N bit changes: 1 + N·(delay+1) edges from IDLE to re-entering IDLE; done is high in the cycle after the last of these.
- cfg handshake: transfer on an edge with cfg_valid & cfg_ready. The earliest sequence start is the following edge.
- Arithmetic:
  - cnt is unsigned and never decremented below 1 in WAIT.
  - delay=2^CNTW−1 is legal and gives the maximum wait.

## Test plan
- Reset, INIT=8'hFF, DELAY=3: ioring[0] rises at edge 2 and ioring[k] at edge 2+4k, so ioring=8'hFF after edge 30. State returns to IDLE at edge 33, with done high for one cycle after it and busy low from then on.
- From 8'hFF, cfg_target=8'h0F, cfg_delay=0 accepted in IDLE: bits 7,6,5,4 clear on four consecutive edges (descending order), then done pulses. cfg_ready stays low throughout.
- Mixed direction, ring=8'h0F, cfg_target=8'hF0, delay=1: bits 3,2,1,0 clear first, then bits 4,5,6,7 set, every 2 cycles; 8 changes in total.
- cfg_valid held high while busy: cfg_ready=0 and target unchanged until IDLE. The transfer happens on the first IDLE edge and the new sequence starts on the next edge.
- rst pulsed in WAIT midway through a ring bring-up: ioring=0 on the next edge, target=INIT, and the sequence restarts from bit 0 with no done pulse for the aborted run.
- cfg_target equal to the current ioring: accepted, then no STEP occurs, busy stays 0 and done stays 0.
